// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM block: mode encodings, defaults and select decoding.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_WIDTH = 10;

    // The period shadow sits at the select value just past the last channel.
    function automatic int sel_period(input int n_ch);
        return n_ch;
    endfunction

endpackage

// File: rtl/pwm_multicanal_if.sv
// Shadow-register write bus: one write per cycle, always accepted, wr_err flags a bad select.
interface pwm_multicanal_if
    import pwm_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int SEL_W = $clog2(N_CH + 1);

    logic             wr_valid;
    logic [SEL_W-1:0] wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic             wr_err;

    modport master (output wr_valid, output wr_sel, output wr_data, input wr_err);
    modport slave  (input wr_valid, input wr_sel, input wr_data, output wr_err);

endinterface

// File: rtl/pwm_canal.sv
// One PWM channel: duty shadow, duty active (loaded on boundary) and registered comparator.
module pwm_canal
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             load,
    input  logic [WIDTH-1:0] count,
    input  logic             run,
    output logic             pwm
);

    logic [WIDTH-1:0] d_shd_q, d_shd_d;
    logic [WIDTH-1:0] d_act_q, d_act_d;
    logic             pwm_q, pwm_d;

    // Compare uses the duty active during this cycle; a load on the same edge applies next period.
    always_comb begin
        d_shd_d = wr_en ? wr_data : d_shd_q;
        d_act_d = load ? d_shd_q : d_act_q;
        pwm_d   = run && (count < d_act_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_shd_q <= '0;
            d_act_q <= '0;
            pwm_q   <= 1'b0;
        end else begin
            d_shd_q <= d_shd_d;
            d_act_q <= d_act_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/pwm_multicanal.sv
// Multi-channel PWM: shared edge/center-aligned period counter, per-channel duty compare.
// Period, duty and mode changes land only at the period boundary so outputs never glitch.
module pwm_multicanal
    import pwm_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = $clog2(N_CH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    pwm_multicanal_if.slave  wr,
    output logic [N_CH-1:0]  pwm,
    output logic             period_tick,
    output logic [WIDTH-1:0] count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    localparam logic [SEL_W-1:0] SEL_P = SEL_W'(sel_period(N_CH));

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] p_act_q, p_act_d;
    logic [WIDTH-1:0] p_shd_q, p_shd_d;
    logic [WIDTH-1:0] p_last;
    logic             mode_act_q, mode_act_d;
    logic             err_q, err_d;
    logic             load, run, bnd;

    assign p_last = p_act_q - WIDTH'(1);

    // IDLE covers both "just enabled" and "period is zero": every IDLE cycle reloads from shadows.
    always_comb begin
        load    = 1'b0;
        run     = 1'b0;
        bnd     = 1'b0;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (!enable) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: load = 1'b1;
                ST_UP: begin
                    run = 1'b1;
                    if (cnt_q == p_last) begin
                        if (mode_act_q == MODE_CENTER) state_d = ST_DOWN;
                        else                           bnd     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                ST_DOWN: begin
                    run = 1'b1;
                    if (cnt_q == '0) bnd   = 1'b1;
                    else             cnt_d = cnt_q - WIDTH'(1);
                end
                default: state_d = ST_IDLE;
            endcase
            if (bnd) load = 1'b1;
            if (load) begin
                cnt_d   = '0;
                state_d = (p_shd_q != '0) ? ST_UP : ST_IDLE;
            end
        end
    end

    always_comb begin
        p_shd_d    = (wr.wr_valid && wr.wr_sel == SEL_P) ? wr.wr_data : p_shd_q;
        p_act_d    = load ? p_shd_q : p_act_q;
        mode_act_d = load ? mode : mode_act_q;
        err_d      = wr.wr_valid && (wr.wr_sel > SEL_P);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            p_act_q    <= '0;
            p_shd_q    <= '0;
            mode_act_q <= MODE_EDGE;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p_act_q    <= p_act_d;
            p_shd_q    <= p_shd_d;
            mode_act_q <= mode_act_d;
            err_q      <= err_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [SEL_W-1:0] CH_SEL = SEL_W'(i);
        pwm_canal #(.WIDTH(WIDTH)) u_canal (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr.wr_valid && (wr.wr_sel == CH_SEL)),
            .wr_data (wr.wr_data),
            .load    (load),
            .count   (cnt_q),
            .run     (run),
            .pwm     (pwm[i])
        );
    end

    // Tick flags the last cycle of the period itself, so it is decoded from the current state.
    assign period_tick = bnd && !reset;
    assign count       = cnt_q;
    assign wr.wr_err   = err_q;

endmodule

// File: tb/tb_pwm_multicanal.sv
// Directed bench for pwm_multicanal; observes {wr_err, count, pwm, period_tick} 1ns after each edge.
module tb_pwm_multicanal;
    import pwm_pkg::*;

    localparam int N_CH  = 4;
    localparam int WIDTH = 10;
    localparam int SEL_W = $clog2(N_CH + 1);
    localparam int VW    = 1 + WIDTH + N_CH + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             mode;
    logic [N_CH-1:0]  pwm;
    logic             period_tick;
    logic [WIDTH-1:0] count;

    pwm_multicanal_if #(.N_CH(N_CH), .WIDTH(WIDTH)) wr_bus ();

    pwm_multicanal #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .wr          (wr_bus.slave),
        .pwm         (pwm),
        .period_tick (period_tick),
        .count       (count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_set(input int sel, input int data);
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_sel   = SEL_W'(sel);
        wr_bus.wr_data  = WIDTH'(data);
    endtask

    task automatic wr_idle();
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_sel   = '0;
        wr_bus.wr_data  = '0;
    endtask

    task automatic write_step(input int sel, input int data);
        wr_set(sel, data);
        step();
        wr_idle();
    endtask

    task automatic test_reset();
        logic [VW-1:0] obs, expv;
        wr_idle();
        enable = 1'b0;
        mode   = MODE_EDGE;
        reset  = 1'b1;
        step();
        step();
        obs  = {wr_bus.wr_err, count, pwm, period_tick};
        expv = '0;
        n_chk++;
        if (obs !== expv) $display("FAIL reset_state got %h expected %h", obs, expv);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_edge();
        logic [VW-1:0]   obs, expv;
        logic [N_CH-1:0] ep;
        int c;
        enable = 1'b0;
        mode   = MODE_EDGE;
        write_step(4, 10);
        n_chk++;
        if (wr_bus.wr_err !== 1'b0) $display("FAIL edge_period_sel_no_err got %b expected 0", wr_bus.wr_err);
        else n_pass++;
        write_step(0, 3);
        write_step(1, 0);
        write_step(2, 10);
        write_step(3, 15);
        enable = 1'b1;
        step();
        for (int k = 0; k < 25; k++) begin
            c    = k % 10;
            ep   = (k == 0) ? 4'b0000 : {2'b11, 1'b0, (((k + 9) % 10) < 3)};
            expv = {1'b0, WIDTH'(c), ep, (c == 9)};
            obs  = {wr_bus.wr_err, count, pwm, period_tick};
            n_chk++;
            if (obs !== expv) $display("FAIL edge k=%0d got %h expected %h", k, obs, expv);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_center();
        logic [VW-1:0]   obs, expv;
        logic [N_CH-1:0] ep;
        int c, m, cp;
        enable = 1'b0;
        step();
        mode = MODE_CENTER;
        write_step(4, 8);
        write_step(0, 2);
        enable = 1'b1;
        step();
        for (int k = 0; k < 34; k++) begin
            m    = k % 16;
            c    = (m < 8) ? m : 15 - m;
            m    = (k + 15) % 16;
            cp   = (m < 8) ? m : 15 - m;
            ep   = (k == 0) ? 4'b0000 : {2'b11, 1'b0, (cp < 2)};
            expv = {1'b0, WIDTH'(c), ep, ((k % 16) == 15)};
            obs  = {wr_bus.wr_err, count, pwm, period_tick};
            n_chk++;
            if (obs !== expv) $display("FAIL center k=%0d got %h expected %h", k, obs, expv);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_shadow();
        logic [VW-1:0]   obs, expv;
        logic [N_CH-1:0] ep;
        int c, d;
        enable = 1'b0;
        step();
        mode = MODE_EDGE;
        write_step(4, 10);
        write_step(0, 3);
        enable = 1'b1;
        step();
        for (int k = 0; k < 41; k++) begin
            c = k % 10;
            case ((k + 9) / 10)
                0, 1:    d = 3;
                2, 3:    d = 7;
                default: d = 5;
            endcase
            ep   = (k == 0) ? 4'b0000 : {2'b11, 1'b0, (((k + 9) % 10) < d)};
            expv = {1'b0, WIDTH'(c), ep, (c == 9)};
            obs  = {wr_bus.wr_err, count, pwm, period_tick};
            n_chk++;
            if (obs !== expv) $display("FAIL shadow k=%0d got %h expected %h", k, obs, expv);
            else n_pass++;
            // Mid-period write, then a write on the tick cycle itself.
            if (k == 4)       wr_set(0, 7);
            else if (k == 19) wr_set(0, 5);
            else              wr_idle();
            step();
        end
        wr_idle();
    endtask

    task automatic test_period_zero();
        logic [VW-1:0] obs, expv;
        int c;
        reset = 1'b1;
        step();
        reset  = 1'b0;
        enable = 1'b1;
        mode   = MODE_EDGE;
        write_step(0, 2);
        for (int k = 0; k < 4; k++) begin
            obs  = {wr_bus.wr_err, count, pwm, period_tick};
            expv = '0;
            n_chk++;
            if (obs !== expv) $display("FAIL pzero_hold k=%0d got %h expected %h", k, obs, expv);
            else n_pass++;
            step();
        end
        write_step(4, 5);
        obs = {wr_bus.wr_err, count, pwm, period_tick};
        n_chk++;
        if (obs !== '0) $display("FAIL pzero_write_cycle got %h expected 0", obs);
        else n_pass++;
        step();
        for (int k = 0; k < 15; k++) begin
            c    = k % 5;
            expv = {1'b0, WIDTH'(c), 3'b000, ((k != 0) && (((k + 4) % 5) < 2)), (c == 4)};
            obs  = {wr_bus.wr_err, count, pwm, period_tick};
            n_chk++;
            if (obs !== expv) $display("FAIL pzero_run k=%0d got %h expected %h", k, obs, expv);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_bad_sel();
        logic [VW-1:0] obs, expv;
        int t;
        t = 0;
        while (!period_tick && t < 20) begin
            step();
            t++;
        end
        n_chk++;
        if (!period_tick) $display("FAIL badsel_wait_tick got %b expected 1", period_tick);
        else n_pass++;
        step();
        for (int j = 0; j < 16; j++) begin
            expv = {((j == 1) || (j == 2)), WIDTH'(j % 5), 3'b000, (((j + 4) % 5) < 2), ((j % 5) == 4)};
            obs  = {wr_bus.wr_err, count, pwm, period_tick};
            n_chk++;
            if (obs !== expv) $display("FAIL badsel j=%0d got %h expected %h", j, obs, expv);
            else n_pass++;
            if (j == 0)      wr_set(5, 9);
            else if (j == 1) wr_set(7, 3);
            else             wr_idle();
            step();
        end
        wr_idle();
    endtask

    task automatic test_enable_drop();
        logic [VW-1:0] obs, expv;
        enable = 1'b0;
        step();
        write_step(4, 10);
        write_step(0, 6);
        write_step(3, 15);
        enable = 1'b1;
        step();
        repeat (4) step();
        obs  = {wr_bus.wr_err, count, pwm, period_tick};
        expv = {1'b0, WIDTH'(4), 4'b1001, 1'b0};
        n_chk++;
        if (obs !== expv) $display("FAIL endrop_before got %h expected %h", obs, expv);
        else n_pass++;
        enable = 1'b0;
        step();
        obs = {wr_bus.wr_err, count, pwm, period_tick};
        n_chk++;
        if (obs !== '0) $display("FAIL endrop_forced_low got %h expected 0", obs);
        else n_pass++;
        step();
        write_step(0, 2);
        obs = {wr_bus.wr_err, count, pwm, period_tick};
        n_chk++;
        if (obs !== '0) $display("FAIL endrop_disabled_write got %h expected 0", obs);
        else n_pass++;
        enable = 1'b1;
        step();
        obs = {wr_bus.wr_err, count, pwm, period_tick};
        n_chk++;
        if (obs !== '0) $display("FAIL endrop_reenable_first got %h expected 0", obs);
        else n_pass++;
        for (int k = 1; k < 12; k++) begin
            step();
            expv = {1'b0, WIDTH'(k % 10), 1'b1, 2'b00, (((k + 9) % 10) < 2), ((k % 10) == 9)};
            obs  = {wr_bus.wr_err, count, pwm, period_tick};
            n_chk++;
            if (obs !== expv) $display("FAIL endrop_rerun k=%0d got %h expected %h", k, obs, expv);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] obs;
        int t;
        t = 0;
        while (count != WIDTH'(6) && t < 30) begin
            step();
            t++;
        end
        n_chk++;
        if (count !== WIDTH'(6)) $display("FAIL rstmid_wait_count got %0d expected 6", count);
        else n_pass++;
        reset = 1'b1;
        step();
        obs = {wr_bus.wr_err, count, pwm, period_tick};
        n_chk++;
        if (obs !== '0) $display("FAIL rstmid_abort got %h expected 0", obs);
        else n_pass++;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            obs = {wr_bus.wr_err, count, pwm, period_tick};
            n_chk++;
            if (obs !== '0) $display("FAIL rstmid_period_zero k=%0d got %h expected 0", k, obs);
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        mode   = MODE_EDGE;
        wr_idle();
        test_reset();
        test_edge();
        test_center();
        test_shadow();
        test_period_zero();
        test_bad_sel();
        test_enable_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
